// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich scheduler and update datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package izh_pkg;

    localparam int W = 8;
    localparam logic [W-1:0] V_INIT = 8'hBF;  // -65
    localparam logic [W-1:0] U_INIT = 8'hF3;  // -13

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] v;
        logic [W-1:0] u;
    } nstate_t;

    function automatic nstate_t init_state();
        nstate_t s;
        s.v = V_INIT;
        s.u = U_INIT;
        return s;
    endfunction

endpackage

// File: rtl/izh_step_scheduler_if.sv
// Request/acknowledge link between the step scheduler and the izh update datapath.
// Latency: a transfer completes on any rising edge where dp_req && dp_ack.
// Backpressure: the datapath stalls the scheduler by holding dp_ack low; operands stay stable.
interface izh_step_scheduler_if #(
    parameter int W = izh_pkg::W
);
    logic         dp_req;
    logic [W-1:0] dp_v;
    logic [W-1:0] dp_u;
    logic [W-1:0] dp_current;
    logic         dp_ack;
    logic [W-1:0] dp_v_next;
    logic [W-1:0] dp_u_next;
    logic         dp_spike;

    modport master (
        output dp_req, dp_v, dp_u, dp_current,
        input  dp_ack, dp_v_next, dp_u_next, dp_spike
    );

    modport slave (
        input  dp_req, dp_v, dp_u, dp_current,
        output dp_ack, dp_v_next, dp_u_next, dp_spike
    );
endinterface

// File: rtl/izh_state_regfile.sv
// Per-neuron {v,u} and input-current storage with serve and monitor read ports.
// Latency: writes land on the clock edge; both reads are combinational.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads return 0.
module izh_state_regfile
    import izh_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_we,
    input  logic [IDX_W-1:0] st_addr,
    input  nstate_t          st_dat,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [W-1:0]     cur_dat,
    input  logic [IDX_W-1:0] srv_addr,
    output nstate_t          srv_state,
    output logic [W-1:0]     srv_current,
    input  logic [IDX_W-1:0] mon_addr,
    output logic [W-1:0]     mon_v
);
    localparam int AW = $clog2(N_NEURONS);
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_NEURONS);

    function automatic logic in_range(input logic [IDX_W-1:0] a);
        return {1'b0, a} < N_EXT;
    endfunction

    nstate_t      st_q  [N_NEURONS];
    nstate_t      st_d  [N_NEURONS];
    logic [W-1:0] cur_q [N_NEURONS];
    logic [W-1:0] cur_d [N_NEURONS];

    // Next-state of the storage: at most one state write and one current write per cycle.
    always_comb begin
        st_d  = st_q;
        cur_d = cur_q;
        if (st_we && in_range(st_addr)) begin
            st_d[st_addr[AW-1:0]] = st_dat;
        end
        if (cur_we && in_range(cur_addr)) begin
            cur_d[cur_addr[AW-1:0]] = cur_dat;
        end
    end

    // Storage registers; reset reloads the neuron initial state and zero current.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                st_q[i]  <= init_state();
                cur_q[i] <= '0;
            end
        end else begin
            st_q  <= st_d;
            cur_q <= cur_d;
        end
    end

    // Read ports; indices past the last neuron read as zero.
    always_comb begin
        srv_state   = '0;
        srv_current = '0;
        mon_v       = '0;
        if (in_range(srv_addr)) begin
            srv_state   = st_q[srv_addr[AW-1:0]];
            srv_current = cur_q[srv_addr[AW-1:0]];
        end
        if (in_range(mon_addr)) begin
            mon_v = st_q[mon_addr[AW-1:0]].v;
        end
    end

endmodule

// File: rtl/izh_step_scheduler.sv
// Time-multiplexes one izh update datapath over N_NEURONS neurons per tick.
// Latency: with dp_ack tied high a step takes N transfer cycles plus one DONE cycle.
// Backpressure: waits on dp_ack with operands held; ticks arriving while busy are dropped with overrun.
module izh_step_scheduler
    import izh_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  logic [W-1:0]          cfg_current,
    izh_step_scheduler_if.master  dp,
    input  logic [IDX_W-1:0]      mon_addr,
    output logic [W-1:0]          mon_v,
    output logic                  busy,
    output logic                  step_done,
    output logic [N_NEURONS-1:0]  spike_vec,
    output logic                  overrun
);
    localparam int AW = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_NEURONS-1:0] shadow_q, shadow_d;
    logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [W-1:0]         dp_v_q, dp_v_d;
    logic [W-1:0]         dp_u_q, dp_u_d;
    logic [W-1:0]         dp_cur_q, dp_cur_d;
    logic [W-1:0]         mon_v_q, mon_v_d;

    logic                 xfer;
    logic                 load;
    logic [IDX_W-1:0]     srv_addr;
    nstate_t              srv_state;
    nstate_t              wb_state;
    logic [W-1:0]         srv_current;
    logic [W-1:0]         rf_mon_v;

    assign wb_state = '{v: dp.dp_v_next, u: dp.dp_u_next};

    izh_state_regfile #(
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .st_we       (xfer),
        .st_addr     (idx_q),
        .st_dat      (wb_state),
        .cur_we      (cfg_we),
        .cur_addr    (cfg_addr),
        .cur_dat     (cfg_current),
        .srv_addr    (srv_addr),
        .srv_state   (srv_state),
        .srv_current (srv_current),
        .mon_addr    (mon_addr),
        .mon_v       (rf_mon_v)
    );

    // Step sequencer: walks idx through the neurons, one datapath transfer each.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        spike_vec_d = spike_vec_q;
        load        = 1'b0;
        xfer        = (state_q == REQ) && dp.dp_ack;
        // Entry being entered next: neuron 0 from IDLE, otherwise the one after idx.
        srv_addr    = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = REQ;
                    idx_d    = '0;
                    shadow_d = '0;
                    load     = 1'b1;
                end
            end
            REQ: begin
                if (xfer) begin
                    shadow_d[idx_q[AW-1:0]] = dp.dp_spike;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                spike_vec_d = shadow_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only when a neuron is entered, so later cfg writes cannot disturb them.
    always_comb begin
        dp_v_d   = load ? srv_state.v : dp_v_q;
        dp_u_d   = load ? srv_state.u : dp_u_q;
        dp_cur_d = load ? srv_current : dp_cur_q;
        mon_v_d  = rf_mon_v;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            spike_vec_q <= '0;
            dp_v_q      <= '0;
            dp_u_q      <= '0;
            dp_cur_q    <= '0;
            mon_v_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            spike_vec_q <= spike_vec_d;
            dp_v_q      <= dp_v_d;
            dp_u_q      <= dp_u_d;
            dp_cur_q    <= dp_cur_d;
            mon_v_q     <= mon_v_d;
        end
    end

    assign dp.dp_req     = (state_q == REQ);
    assign dp.dp_v       = dp_v_q;
    assign dp.dp_u       = dp_u_q;
    assign dp.dp_current = dp_cur_q;
    assign busy          = (state_q != IDLE);
    assign step_done     = (state_q == DONE);
    assign overrun       = tick && (state_q != IDLE);
    assign spike_vec     = spike_vec_q;
    assign mon_v         = mon_v_q;

endmodule
